// File: rtl/zbt_sram_responder.sv
// ZBT/NoBL SRAM stand-in: load/advance command decode, 4-beat linear bursts,
// and a fixed two-stage pipeline into per-byte-lane on-chip RAM.

module zbt_sram_lane #(
  parameter int AW = 10,
  parameter int LW = 9
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [LW-1:0] wdata_i,
  output logic [LW-1:0] rdata_o
);
  logic [LW-1:0] mem_q [2**AW];
  logic [LW-1:0] rdata_q;

  always_ff @(posedge clk_i)
    if (we_i) mem_q[addr_i] <= wdata_i;

  // Read-first: a same-edge write to this address is not visible here.
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];

  assign rdata_o = rdata_q;
endmodule

module zbt_sram_responder #(
  parameter int ASIZE     = 18,
  parameter int DSIZE     = 36,
  parameter int BWSIZE    = 4,
  parameter int MEM_ASIZE = 10
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ce_n_i,
  input  logic [ASIZE-1:0]  addr_i,
  input  logic              rd_wr_n_i,
  input  logic              addr_adv_ld_n_i,
  input  logic [DSIZE-1:0]  data_in_i,
  input  logic [BWSIZE-1:0] dm_i,
  output logic [DSIZE-1:0]  data_out_o,
  output logic              data_out_valid_o
);
  localparam int LW     = DSIZE / BWSIZE;
  localparam int STAGES = 2;

  typedef struct packed {
    logic                 rd;
    logic [MEM_ASIZE-1:0] a;
  } cmd_t;

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e               state_q, state_d;
  logic                 op_q, op_d;
  logic [MEM_ASIZE-1:0] base_q, base_d;
  logic [1:0]           cnt_q, cnt_d;

  logic                 cmd_vld;
  cmd_t                 cmd;
  logic [STAGES:1]      vld_pipe_q;
  cmd_t [STAGES:1]      cmd_pipe_q;
  logic                 dvld_q;

  logic                 act_rd, act_wr;
  cmd_t                 act;

  logic [BWSIZE-1:0][LW-1:0] wdata, rdata;

  // Upper address bits alias onto the implemented depth.
  logic unused_addr;
  assign unused_addr = ^addr_i[ASIZE-1:MEM_ASIZE];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    cmd_vld = 1'b0;
    cmd.rd  = op_q;
    cmd.a   = base_q;
    if (!addr_adv_ld_n_i) begin
      if (!ce_n_i) begin
        state_d = S_BURST;
        op_d    = rd_wr_n_i;
        base_d  = addr_i[MEM_ASIZE-1:0];
        cnt_d   = 2'd0;
        cmd_vld = 1'b1;
        cmd.rd  = rd_wr_n_i;
        cmd.a   = addr_i[MEM_ASIZE-1:0];
      end else begin
        state_d = S_IDLE;
      end
    end else if (state_q == S_BURST) begin
      // Linear burst wraps inside the aligned 4-word block.
      cnt_d   = cnt_q + 2'd1;
      cmd_vld = 1'b1;
      cmd.a   = {base_q[MEM_ASIZE-1:2], base_q[1:0] + cnt_d};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      op_q       <= 1'b0;
      base_q     <= '0;
      cnt_q      <= '0;
      vld_pipe_q <= '0;
      cmd_pipe_q <= '0;
      dvld_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      base_q        <= base_d;
      cnt_q         <= cnt_d;
      vld_pipe_q[1] <= cmd_vld;
      cmd_pipe_q[1] <= cmd;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        cmd_pipe_q[s] <= cmd_pipe_q[s-1];
      end
      dvld_q <= act_rd;
    end
  end

  assign act    = cmd_pipe_q[STAGES];
  assign act_rd = vld_pipe_q[STAGES] & act.rd;
  assign act_wr = vld_pipe_q[STAGES] & ~act.rd;
  assign wdata  = data_in_i;

  for (genvar g = 0; g < BWSIZE; g++) begin : g_lane
    zbt_sram_lane #(.AW(MEM_ASIZE), .LW(LW)) u_lane (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .we_i    (act_wr & ~dm_i[g]),
      .re_i    (act_rd),
      .addr_i  (act.a),
      .wdata_i (wdata[g]),
      .rdata_o (rdata[g])
    );
  end

  assign data_out_o       = rdata;
  assign data_out_valid_o = dvld_q;
endmodule

// File: tb/tb_zbt_sram_responder.sv
// Bench for zbt_sram_responder: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.

module tb_zbt_sram_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce_n = 1'b1;
  logic [17:0] addr = '0;
  logic        rd_wr_n = 1'b1;
  logic        ld_n = 1'b0;
  logic [35:0] data_in = '0;
  logic [3:0]  dm = 4'hF;
  logic [35:0] data_out;
  logic        data_out_valid;

  int checks = 0;
  int failures = 0;

  zbt_sram_responder dut (
    .clk_i(clk), .reset_i(reset), .ce_n_i(ce_n), .addr_i(addr),
    .rd_wr_n_i(rd_wr_n), .addr_adv_ld_n_i(ld_n), .data_in_i(data_in),
    .dm_i(dm), .data_out_o(data_out), .data_out_valid_o(data_out_valid)
  );

  always #5 clk = ~clk;

  // Behavioural model: memory with per-lane "known" flags, a two-deep queue of
  // pending actions, and the current burst described by base/count.
  logic [35:0] mmem [1024];
  logic [3:0]  mknown [1024];
  bit          p1v, p1rd, p2v, p2rd;
  int          p1a, p2a;
  bit          b_on, b_rd;
  int          b_base, b_cnt;
  bit          e_vld;
  logic [35:0] e_dout;
  logic [3:0]  e_known;

  task automatic mdl_reset();
    p1v = 0; p2v = 0; b_on = 0;
    e_vld = 0; e_dout = '0; e_known = 4'hF;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin mmem[i] = '0; mknown[i] = '0; end
    mdl_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) mdl_reset();
      else begin
        e_vld = p2v && p2rd;
        if (e_vld) begin
          e_dout  = mmem[p2a];
          e_known = mknown[p2a];
        end else if (p2v) begin
          for (int l = 0; l < 4; l++)
            if (!dm[l]) begin
              mmem[p2a][l*9 +: 9] = data_in[l*9 +: 9];
              mknown[p2a][l] = 1'b1;
            end
        end
        p2v = p1v; p2rd = p1rd; p2a = p1a;
        if (!ld_n) begin
          if (!ce_n) begin
            b_on = 1; b_rd = rd_wr_n; b_base = int'(addr) % 1024; b_cnt = 0;
            p1v = 1; p1rd = b_rd; p1a = b_base;
          end else begin
            b_on = 0; p1v = 0;
          end
        end else if (b_on) begin
          b_cnt = (b_cnt + 1) % 4;
          p1v = 1; p1rd = b_rd; p1a = (b_base / 4) * 4 + (b_base + b_cnt) % 4;
        end else p1v = 0;
      end
    end
  end

  // Every-cycle compare against the model.
  initial begin
    logic [35:0] kmask;
    forever begin
      @(negedge clk);
      checks++;
      if (data_out_valid !== e_vld) begin
        failures++;
        $display("FAIL cyc_valid t=%0t got=%0b exp=%0b", $time, data_out_valid, e_vld);
      end
      for (int l = 0; l < 4; l++) kmask[l*9 +: 9] = {9{e_known[l]}};
      if (kmask != '0) begin
        checks++;
        if (((data_out ^ e_dout) & kmask) !== 36'h0) begin
          failures++;
          $display("FAIL cyc_dout t=%0t got=%h exp=%h mask=%h", $time, data_out, e_dout, kmask);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Write data belongs to the command issued two cycles earlier.
  logic [35:0] pd0 = '0, pd1 = '0;
  logic [3:0]  pm0 = 4'hF, pm1 = 4'hF;

  task automatic cmd(input bit l_n, input bit c_n, input bit rd, input logic [17:0] a,
                     input logic [35:0] wd, input logic [3:0] wm);
    data_in = pd1; dm = pm1;
    pd1 = pd0; pm1 = pm0; pd0 = wd; pm0 = wm;
    ld_n = l_n; ce_n = c_n; rd_wr_n = rd; addr = a;
    @(negedge clk); #1;
  endtask

  task automatic wr(input logic [17:0] a, input logic [35:0] d, input logic [3:0] m);
    cmd(1'b0, 1'b0, 1'b0, a, d, m);
  endtask
  task automatic rdc(input logic [17:0] a);
    cmd(1'b0, 1'b0, 1'b1, a, '0, 4'hF);
  endtask
  task automatic nop();
    cmd(1'b0, 1'b1, 1'b1, '0, '0, 4'hF);
  endtask
  task automatic adv(input logic [35:0] d, input logic [3:0] m);
    cmd(1'b1, 1'b0, 1'b0, '0, d, m);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    pd0 = '0; pd1 = '0; pm0 = 4'hF; pm1 = 4'hF;
    repeat (n) begin @(negedge clk); #1; end
    reset = 1'b0;
  endtask

  initial begin
    logic [63:0] r;
    @(negedge clk); #1;
    chk("reset_dout", data_out, 36'h0);
    chk("reset_valid", {35'h0, data_out_valid}, 36'h0);
    do_reset(2);

    // Basic write then read with 2-edge latency
    wr(18'h010, 36'h123456789, 4'h0); nop(); nop();
    rdc(18'h010); nop();
    chk("t1_valid_early", {35'h0, data_out_valid}, 36'h0);
    nop();
    chk("t1_dout", data_out, 36'h123456789);
    chk("t1_valid", {35'h0, data_out_valid}, 36'h1);

    // Byte-masked write
    wr(18'h020, 36'hFFFFFFFFF, 4'h0); wr(18'h020, 36'h0, 4'b1010);
    rdc(18'h020); nop(); nop();
    chk("t2_mask", data_out, 36'hFF803FE00);

    // Burst wrap inside 4-word block
    wr(18'h042, 36'd1, 4'h0); adv(36'd2, 4'h0); adv(36'd3, 4'h0); adv(36'd4, 4'h0);
    nop(); nop();
    rdc(18'h040); adv('0, 4'hF); adv('0, 4'hF);
    chk("t3_beat0", data_out, 36'd3);
    adv('0, 4'hF);
    chk("t3_beat1", data_out, 36'd4);
    nop();
    chk("t3_beat2", data_out, 36'd1);
    nop();
    chk("t3_beat3", data_out, 36'd2);

    // Read-after-write and write-after-read ordering
    wr(18'h051, 36'h77, 4'h0); wr(18'h050, 36'hAA, 4'h0); rdc(18'h050); nop(); nop();
    chk("t4_raw", data_out, 36'hAA);
    rdc(18'h051); wr(18'h051, 36'hBB, 4'h0); nop();
    chk("t4_war_old", data_out, 36'h77);
    nop(); rdc(18'h051); nop(); nop();
    chk("t4_war_new", data_out, 36'hBB);

    // Advances with no active burst are NOPs; aliasing of upper address bits
    do_reset(1);
    adv(36'hFFF, 4'h0); adv(36'hFFF, 4'h0); adv(36'hFFF, 4'h0);
    chk("t5_adv_rst_valid", {35'h0, data_out_valid}, 36'h0);
    nop(); adv(36'hEEE, 4'h0); adv(36'hEEE, 4'h0); nop(); nop();
    chk("t5_adv_desel_valid", {35'h0, data_out_valid}, 36'h0);
    rdc(18'h010); nop(); nop();
    chk("t5_ram_intact", data_out, 36'h123456789);
    wr(18'h00400, 36'h5A5, 4'h0); nop(); nop();
    rdc(18'h00000); nop(); nop();
    chk("t5_alias", data_out, 36'h5A5);

    // Reset with a write in flight drops it
    wr(18'h060, 36'h111, 4'h0); nop(); nop();
    wr(18'h060, 36'h222, 4'h0);
    do_reset(2);
    chk("t6_valid", {35'h0, data_out_valid}, 36'h0);
    rdc(18'h060); nop(); nop();
    chk("t6_prior", data_out, 36'h111);

    // Randomized traffic, checked by the per-cycle compare
    for (int i = 0; i < 3000; i++) begin
      logic [17:0] a;
      logic [3:0]  m;
      r = {$urandom(), $urandom()};
      a = {r[63:56], 4'h0, r[5:0]};
      m = ($urandom_range(0, 3) == 0) ? 4'(r[11:8]) : 4'h0;
      if ($urandom_range(0, 499) == 0) do_reset(int'($urandom_range(1, 2)));
      else cmd(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) == 0),
               r[7], a, {r[47:12]}, m);
    end
    repeat (3) nop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
